alu_share_ctrl: RTL and testbench
=================================

Name: alu_share_ctrl

Overview:
Sequencer and round-robin arbiter that shares one combinational ALU datapath between two requesters. Operations include zero counting, add and logic ops.
- Each requester issues an op via a valid/ready command handshake.
- The controller latches the operands and drives the ALU for a configurable number of settle cycles.
- It captures the result and carry, then returns them on a valid/ready response handshake to the granted requester.
- Sits between the register/command front-end and the ALU top.

Parameters:
LEN, 4, operand/result width in bits (matches ALU LEN)
OPW, 3, opcode width
EXEC_CYCLES, 1, ALU settle cycles before capture; legal 1..15

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  reset, asynchronous, active-low
i_req0_valid  in  1  requester 0 command valid
o_req0_ready  out  1  requester 0 command accepted this cycle
i_req0_op  in  OPW  requester 0 opcode
i_req0_a  in  LEN  requester 0 operand A (signed)
i_req0_b  in  LEN  requester 0 operand B (signed)
i_req1_valid, o_req1_ready, i_req1_op, i_req1_a, i_req1_b  as above for requester 1
o_rsp0_valid  out  1  response valid for requester 0
i_rsp0_ready  in  1  requester 0 takes response
o_rsp1_valid  out  1  response valid for requester 1
i_rsp1_ready  in  1  requester 1 takes response
o_rsp_data  out  LEN  captured ALU result (shared bus)
o_rsp_carry  out  1  captured ALU carry
o_alu_op  out  OPW  opcode to ALU
o_alu_a  out  LEN  operand A to ALU
o_alu_b  out  LEN  operand B to ALU
i_alu_result  in  LEN  ALU result
i_alu_carry  in  1  ALU carry
o_busy  out  1  high in any state except IDLE
o_grant_id  out  1  requester currently owning the ALU

Behaviour:
- Reset (async, i_rst_n=0):
  - State goes to IDLE and last_grant=1, so requester 0 wins first.
  - All outputs and internal registers go to 0: ready, rsp_valid, rsp_data, rsp_carry, alu_op/a/b, busy, grant_id, exec counter.
  - Reset mid-operation aborts the op; no response is issued after release.
- States are IDLE, EXEC and RESP.
- IDLE:
  - Winner is the single valid requester. If both are valid, the winner is the requester other than last_grant.
  - o_reqN_ready is driven combinationally high for the winner only, and only in IDLE. Transfer happens when valid && ready.
  - On transfer: latch op/a/b into the ALU drive registers, set grant_id=winner, load counter=EXEC_CYCLES-1, go to EXEC.
- EXEC:
  - o_alu_* hold the latched values and stay stable.
  - If counter==0, capture i_alu_result/i_alu_carry into o_rsp_data/o_rsp_carry and go to RESP. Otherwise decrement the counter.
- RESP:
  - o_rspN_valid=1 for N=grant_id; the other valid stays 0.
  - Data and carry are held stable while valid && !ready.
  - On the ready handshake: valid drops next cycle, last_grant=grant_id, go to IDLE.
  - No new command is accepted in RESP.
- Latency: command accepted at cycle T gives rsp_valid at T+EXEC_CYCLES+1. Minimum issue interval is EXEC_CYCLES+2 cycles with zero response backpressure.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1.
- A requester dropping valid without a handshake is legal; that request is simply not granted.
- The opcode is not decoded; it passes to the ALU unchanged.
- o_alu_* retain their last values in IDLE (no toggling).
- rsp_ready asserted outside RESP, or by the non-granted requester, is ignored.

Decomposition:
- Shared package alu_pkg holds:
  - the opcode typedef, enum of width OPW, shared with the ALU top
  - the ctrl_state_t enum {IDLE, EXEC, RESP}
  - the default LEN/OPW constants
- Sub-module rr_arb2: 2-input round-robin picker. Inputs are the two valids and last_grant; outputs are the one-hot grant and the winner id. It is purely combinational; last_grant is held in the controller.

Test Plan:
- Reset released with req0: op=COUNT_ZEROS, a=4'b0000, b=4'b0101 -> ready0 high in the same cycle. o_alu_a=0, o_alu_b=5 next cycle. rsp0_valid at T+2 with data=6 (model ALU), carry=0. rsp1_valid stays 0.
- Both requesters valid for 4 back-to-back ops, rsp_ready always 1 -> grant order 0,1,0,1; each response is routed to the correct valid; interval is 3 cycles.
- EXEC_CYCLES=4, one request -> rsp_valid exactly 5 cycles after the handshake; o_alu_* stable throughout EXEC.
- Backpressure: rsp0_ready held low 6 cycles while req1 is valid -> data/carry stable, req1_ready stays 0. After the ready handshake, the next cycle is IDLE and req1 is granted.
- Count-zeros overflow: LEN=4, a=0, b=0 -> ALU gives result 8 with carry 0, or carry 1 for an overflowing op. The captured carry matches i_alu_carry at the capture cycle.
- Reset asserted in EXEC and in RESP -> all outputs 0 asynchronously. After release, no stale rsp_valid appears and the first grant goes to requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, controller states and default widths.
package alu_pkg;

  localparam int unsigned LEN_DEF = 4;
  localparam int unsigned OPW_DEF = 3;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [OPW_DEF-1:0] {
    OP_ADD         = 3'd0,
    OP_SUB         = 3'd1,
    OP_AND         = 3'd2,
    OP_OR          = 3'd3,
    OP_XOR         = 3'd4,
    OP_COUNT_ZEROS = 3'd5,
    OP_RSV6        = 3'd6,
    OP_RSV7        = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker; the requester that did not win last gets priority.
module rr_arb2 (
  input  logic       i_valid0,
  input  logic       i_valid1,
  input  logic       i_last_grant,
  output logic [1:0] o_grant_c,
  output logic       o_winner_c
);

  always_comb begin
    o_grant_c  = 2'b00;
    o_winner_c = 1'b0;
    if (i_valid0 && i_valid1) begin
      o_winner_c = ~i_last_grant;
      o_grant_c  = i_last_grant ? 2'b01 : 2'b10;
    end else if (i_valid0) begin
      o_winner_c = 1'b0;
      o_grant_c  = 2'b01;
    end else if (i_valid1) begin
      o_winner_c = 1'b1;
      o_grant_c  = 2'b10;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters: accept a command, let the
// ALU settle for EXEC_CYCLES, capture the result and hand it back to the owner.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned LEN         = LEN_DEF,
  parameter int unsigned OPW         = OPW_DEF,
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_req0_valid,
  output logic           o_req0_ready,
  input  logic [OPW-1:0] i_req0_op,
  input  logic [LEN-1:0] i_req0_a,
  input  logic [LEN-1:0] i_req0_b,
  input  logic           i_req1_valid,
  output logic           o_req1_ready,
  input  logic [OPW-1:0] i_req1_op,
  input  logic [LEN-1:0] i_req1_a,
  input  logic [LEN-1:0] i_req1_b,
  output logic           o_rsp0_valid,
  input  logic           i_rsp0_ready,
  output logic           o_rsp1_valid,
  input  logic           i_rsp1_ready,
  output logic [LEN-1:0] o_rsp_data,
  output logic           o_rsp_carry,
  output logic [OPW-1:0] o_alu_op,
  output logic [LEN-1:0] o_alu_a,
  output logic [LEN-1:0] o_alu_b,
  input  logic [LEN-1:0] i_alu_result,
  input  logic           i_alu_carry,
  output logic           o_busy,
  output logic           o_grant_id
);

  ctrl_state_t      state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             grant_id_q, grant_id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OPW-1:0]   alu_op_q, alu_op_d;
  logic [LEN-1:0]   alu_a_q, alu_a_d;
  logic [LEN-1:0]   alu_b_q, alu_b_d;
  logic [LEN-1:0]   rsp_data_q, rsp_data_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             rsp0_valid_q, rsp0_valid_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic             busy_q, busy_d;

  logic [1:0]       grant_c;
  logic             winner_c;
  logic             rsp_take_c;

  rr_arb2 u_arb (
    .i_valid0     (i_req0_valid),
    .i_valid1     (i_req1_valid),
    .i_last_grant (last_grant_q),
    .o_grant_c    (grant_c),
    .o_winner_c   (winner_c)
  );

  // Ready is only offered while idle, so a grant there is the transfer itself.
  assign o_req0_ready = (state_q == IDLE) && grant_c[0];
  assign o_req1_ready = (state_q == IDLE) && grant_c[1];
  assign rsp_take_c   = grant_id_q ? i_rsp1_ready : i_rsp0_ready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    cnt_d        = cnt_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_data_d   = rsp_data_q;
    rsp_carry_d  = rsp_carry_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;

    unique case (state_q)
      IDLE: begin
        if (grant_c != 2'b00) begin
          state_d    = EXEC;
          grant_id_d = winner_c;
          cnt_d      = CNT_W'(EXEC_CYCLES - 1);
          alu_op_d   = winner_c ? i_req1_op : i_req0_op;
          alu_a_d    = winner_c ? i_req1_a  : i_req0_a;
          alu_b_d    = winner_c ? i_req1_b  : i_req0_b;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          state_d      = RESP;
          rsp_data_d   = i_alu_result;
          rsp_carry_d  = i_alu_carry;
          rsp0_valid_d = ~grant_id_q;
          rsp1_valid_d = grant_id_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_take_c) begin
          state_d      = IDLE;
          last_grant_d = grant_id_q;
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      cnt_q        <= '0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_data_q   <= '0;
      rsp_carry_q  <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      cnt_q        <= cnt_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_data_q   <= rsp_data_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign o_rsp0_valid = rsp0_valid_q;
  assign o_rsp1_valid = rsp1_valid_q;
  assign o_rsp_data   = rsp_data_q;
  assign o_rsp_carry  = rsp_carry_q;
  assign o_alu_op     = alu_op_q;
  assign o_alu_a      = alu_a_q;
  assign o_alu_b      = alu_b_q;
  assign o_busy       = busy_q;
  assign o_grant_id   = grant_id_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: directed table, fairness/backpressure/reset sequences,
// randomized traffic against a timestamp-based reference model, and a long-settle instance.
module tb_alu_share_ctrl;

  localparam int unsigned LEN = 4;
  localparam int unsigned OPW = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic           v0, v1, rr0, rr1;
  logic [OPW-1:0] op0, op1;
  logic [LEN-1:0] a0, b0, a1, b1;
  logic           rdy0, rdy1, rv0, rv1, rsp_carry, alu_carry, busy, gid;
  logic [LEN-1:0] rsp_data, alu_a, alu_b, alu_res;
  logic [OPW-1:0] alu_op;

  logic           d4_v0, d4_rr0, d4_rdy0, d4_rdy1, d4_rv0, d4_rv1, d4_carry, d4_alu_carry;
  logic           d4_busy, d4_gid;
  logic [LEN-1:0] d4_data, d4_alu_a, d4_alu_b, d4_alu_res;
  logic [OPW-1:0] d4_alu_op;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference ALU: {carry, result}; SUB carry is the borrow, count-zeros spans both operands.
  function automatic logic [4:0] alu_ref(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] r;
    int z;
    r = '0;
    z = 0;
    case (op)
      3'd0: r = {1'b0, a} + {1'b0, b};
      3'd1: r = {1'b0, a} - {1'b0, b};
      3'd2: r = {1'b0, a & b};
      3'd3: r = {1'b0, a | b};
      3'd4: r = {1'b0, a ^ b};
      3'd5: begin
        for (int i = 0; i < 4; i++) begin
          if (!a[i]) z++;
          if (!b[i]) z++;
        end
        r = 5'(z);
      end
      default: r = {1'b0, a};
    endcase
    return r;
  endfunction

  assign {alu_carry, alu_res}       = alu_ref(alu_op, alu_a, alu_b);
  assign {d4_alu_carry, d4_alu_res} = alu_ref(d4_alu_op, d4_alu_a, d4_alu_b);

  alu_share_ctrl #(.LEN(LEN), .OPW(OPW), .EXEC_CYCLES(1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(v0), .o_req0_ready(rdy0), .i_req0_op(op0), .i_req0_a(a0), .i_req0_b(b0),
    .i_req1_valid(v1), .o_req1_ready(rdy1), .i_req1_op(op1), .i_req1_a(a1), .i_req1_b(b1),
    .o_rsp0_valid(rv0), .i_rsp0_ready(rr0), .o_rsp1_valid(rv1), .i_rsp1_ready(rr1),
    .o_rsp_data(rsp_data), .o_rsp_carry(rsp_carry),
    .o_alu_op(alu_op), .o_alu_a(alu_a), .o_alu_b(alu_b),
    .i_alu_result(alu_res), .i_alu_carry(alu_carry),
    .o_busy(busy), .o_grant_id(gid)
  );

  alu_share_ctrl #(.LEN(LEN), .OPW(OPW), .EXEC_CYCLES(4)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(d4_v0), .o_req0_ready(d4_rdy0), .i_req0_op(3'd0), .i_req0_a(4'hF), .i_req0_b(4'h1),
    .i_req1_valid(1'b0), .o_req1_ready(d4_rdy1), .i_req1_op(3'd0), .i_req1_a(4'h0), .i_req1_b(4'h0),
    .o_rsp0_valid(d4_rv0), .i_rsp0_ready(d4_rr0), .o_rsp1_valid(d4_rv1), .i_rsp1_ready(1'b0),
    .o_rsp_data(d4_data), .o_rsp_carry(d4_carry),
    .o_alu_op(d4_alu_op), .o_alu_a(d4_alu_a), .o_alu_b(d4_alu_b),
    .i_alu_result(d4_alu_res), .i_alu_carry(d4_alu_carry),
    .o_busy(d4_busy), .o_grant_id(d4_gid)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: one outstanding op, response valid from accept+EXEC_CYCLES+1 until taken.
  bit         m_have;
  bit         m_id;
  bit         m_last;
  logic [4:0] m_exp;
  int         m_acc;
  int         cyc;
  int         acc_cyc_q[$];
  bit         acc_id_q[$];

  // Inputs are driven just after a negedge; check, advance the model, move to the next negedge.
  task automatic tick();
    bit exp_rv, win, win_ok;
    #1;
    exp_rv = m_have && (cyc >= m_acc + 2);
    check("rsp0_valid", rv0, exp_rv && !m_id);
    check("rsp1_valid", rv1, exp_rv && m_id);
    check("busy", busy, m_have);
    if (m_have) check("grant_id", gid, m_id);
    if (exp_rv) check("rsp_data_carry", {rsp_carry, rsp_data}, m_exp);
    win = 1'b0;
    win_ok = !m_have && (v0 || v1);
    if (v0 && v1) win = !m_last;
    else if (v1)  win = 1'b1;
    check("req0_ready", rdy0, win_ok && !win);
    check("req1_ready", rdy1, win_ok && win);
    if (exp_rv && (m_id ? rr1 : rr0)) begin
      m_have = 1'b0;
      m_last = m_id;
    end else if (win_ok) begin
      m_have = 1'b1;
      m_id   = win;
      m_acc  = cyc;
      m_exp  = win ? alu_ref(op1, a1, b1) : alu_ref(op0, a0, b0);
      acc_cyc_q.push_back(cyc);
      acc_id_q.push_back(win);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    v0 = 1'b0;
    v1 = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", {rv0, rv1}, 2'b00);
    check("rst_ready", {rdy0, rdy1}, 2'b00);
    check("rst_rsp", {rsp_carry, rsp_data}, 5'h0);
    check("rst_alu", {alu_op, alu_a, alu_b}, 11'h0);
    check("rst_busy_gid", {busy, gid}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    m_have = 1'b0;
    m_last = 1'b1;
    cyc++;
  endtask

  task automatic drain();
    v0 = 1'b0;
    v1 = 1'b0;
    rr0 = 1'b1;
    rr1 = 1'b1;
    for (int k = 0; k < 10 && m_have; k++) tick();
    check("drain_done", 32'(m_have), 32'd0);
  endtask

  typedef struct {
    bit         id;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] exp_data;
    logic       exp_carry;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int seen;
    int hs;
    int k;
    logic [3:0] sa, sb;

    vecs[0] = '{1'b0, 3'd5, 4'h0, 4'h5, 4'h6, 1'b0};
    vecs[1] = '{1'b1, 3'd0, 4'h7, 4'h1, 4'h8, 1'b0};
    vecs[2] = '{1'b0, 3'd0, 4'hF, 4'h1, 4'h0, 1'b1};
    vecs[3] = '{1'b1, 3'd1, 4'h3, 4'h5, 4'hE, 1'b1};
    vecs[4] = '{1'b0, 3'd2, 4'hC, 4'hA, 4'h8, 1'b0};
    vecs[5] = '{1'b1, 3'd3, 4'hC, 4'hA, 4'hE, 1'b0};
    vecs[6] = '{1'b0, 3'd4, 4'hC, 4'hA, 4'h6, 1'b0};
    vecs[7] = '{1'b1, 3'd5, 4'h0, 4'h0, 4'h8, 1'b0};
    vecs[8] = '{1'b0, 3'd1, 4'h5, 4'h3, 4'h2, 1'b0};

    {v0, v1, rr0, rr1, d4_v0, d4_rr0} = '0;
    {op0, op1, a0, b0, a1, b1} = '0;
    rst_n = 1'b1;
    cyc = 0;
    @(negedge clk);
    do_reset();

    // Directed table: one op at a time, any rsp_ready from the non-owner is ignored.
    rr0 = 1'b1;
    rr1 = 1'b1;
    foreach (vecs[i]) begin
      v0 = !vecs[i].id; v1 = vecs[i].id;
      op0 = vecs[i].op; a0 = vecs[i].a; b0 = vecs[i].b;
      op1 = vecs[i].op; a1 = vecs[i].a; b1 = vecs[i].b;
      tick();
      v0 = 1'b0; v1 = 1'b0;
      check("tbl_alu_ab", {alu_a, alu_b}, {vecs[i].a, vecs[i].b});
      seen = 0;
      for (k = 1; k < 10 && !seen; k++) begin
        if (rv0 || rv1) begin
          seen = 1;
          check("tbl_latency", 32'(k), 32'd2);
          check("tbl_data", rsp_data, vecs[i].exp_data);
          check("tbl_carry", rsp_carry, vecs[i].exp_carry);
          check("tbl_route", {rv1, rv0}, vecs[i].id ? 2'b10 : 2'b01);
        end
        tick();
      end
      check("tbl_rsp_seen", 32'(seen), 32'd1);
    end

    // Fairness: both always valid right after reset -> 0,1,0,1 every 3 cycles.
    do_reset();
    acc_cyc_q.delete();
    acc_id_q.delete();
    rr0 = 1'b1; rr1 = 1'b1;
    v0 = 1'b1; v1 = 1'b1;
    for (k = 0; k < 30 && acc_id_q.size() < 4; k++) begin
      op0 = 3'($urandom_range(0, 5)); a0 = 4'($urandom); b0 = 4'($urandom);
      op1 = 3'($urandom_range(0, 5)); a1 = 4'($urandom); b1 = 4'($urandom);
      tick();
    end
    check("fair_count", 32'(acc_id_q.size()), 32'd4);
    if (acc_id_q.size() >= 4) begin
      for (int j = 0; j < 4; j++) check("fair_order", 32'(acc_id_q[j]), 32'(j % 2));
      for (int j = 1; j < 4; j++) check("fair_interval", 32'(acc_cyc_q[j] - acc_cyc_q[j-1]), 32'd3);
    end
    drain();

    // Backpressure on requester 0 while requester 1 waits.
    v0 = 1'b1; op0 = 3'd0; a0 = 4'h9; b0 = 4'h8;
    rr0 = 1'b0; rr1 = 1'b1;
    tick();
    v0 = 1'b0; v1 = 1'b1; op1 = 3'd4; a1 = 4'h3; b1 = 4'h5;
    seen = 0;
    for (k = 0; k < 30 && seen < 6; k++) begin
      if (rv0) begin
        seen++;
        check("bp_data_hold", {rsp_carry, rsp_data}, 5'h11);
      end
      tick();
    end
    check("bp_cycles", 32'(seen), 32'd6);
    rr0 = 1'b1;
    hs = cyc;
    tick();
    rr0 = 1'b0;
    tick();
    check("bp_next_grant", 32'(acc_id_q[$]), 32'd1);
    check("bp_next_cycle", 32'(acc_cyc_q[$]), 32'(hs + 1));
    v1 = 1'b0;
    drain();

    // Reset in EXEC, then in RESP: no stale response, requester 0 wins first.
    for (int r = 0; r < 2; r++) begin
      v0 = 1'b1; op0 = 3'd3; a0 = 4'h1; b0 = 4'h2;
      rr0 = 1'b0; rr1 = 1'b0;
      tick();
      v0 = 1'b0;
      if (r == 1) tick();
      do_reset();
      for (int j = 0; j < 4; j++) tick();
      v0 = 1'b1; v1 = 1'b1;
      tick();
      check("rst_first_grant", 32'(acc_id_q[$]), 32'd0);
      drain();
    end

    // Randomized traffic with random response backpressure.
    for (int n = 0; n < 600; n++) begin
      v0 = ($urandom_range(0, 2) != 0);
      v1 = ($urandom_range(0, 2) != 0);
      op0 = 3'($urandom_range(0, 7)); a0 = 4'($urandom); b0 = 4'($urandom);
      op1 = 3'($urandom_range(0, 7)); a1 = 4'($urandom); b1 = 4'($urandom);
      rr0 = 1'($urandom); rr1 = 1'($urandom);
      tick();
    end
    drain();

    // Long settle: accept at T, response at T+5, ALU drive stable throughout.
    d4_v0 = 1'b1;
    #1;
    check("d4_ready", d4_rdy0, 1'b1);
    @(negedge clk);
    d4_v0 = 1'b0;
    sa = d4_alu_a;
    sb = d4_alu_b;
    check("d4_alu_ab", {sa, sb}, 8'hF1);
    k = 1;
    while (!d4_rv0 && k < 20) begin
      check("d4_alu_stable", {d4_alu_a, d4_alu_b, d4_busy}, {sa, sb, 1'b1});
      @(negedge clk);
      k++;
    end
    check("d4_latency", 32'(k), 32'd5);
    check("d4_rsp", {d4_carry, d4_data}, 5'h10);
    check("d4_rsp1_quiet", d4_rv1, 1'b0);
    d4_rr0 = 1'b1;
    @(negedge clk);
    check("d4_valid_drop", {d4_rv0, d4_busy}, 2'b00);
    d4_rr0 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
